mips_bus_mem_unit: RTL and testbench
====================================

// Module: mips_bus_mem_unit
// PURPOSE
//  Parametrised load/store unit between the multicycle MIPS core and the Avalon-MM bus.
//  Accepts one core request (byte/half/word, signed/unsigned) and generates an aligned address, byteenable and lane-shifted writedata.
//  Holds the bus request while waitrequest is high, then returns lane-extracted, sign/zero-extended read data.
//  Generalises the bus port to any DATA_WIDTH and reports misalignment.
// PARAMETERS
//  ADDR_WIDTH      32   byte-address width on core and bus side
//  DATA_WIDTH      32   bus data width; 32 or 64; BE_WIDTH = DATA_WIDTH/8 (derived localparam)
//  TIMEOUT_CYCLES  255  waitrequest cycles before abort; used only with MEM_IF_TIMEOUT_EN
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            asynchronous, active-low reset
//  req_valid    in   1            core request strobe
//  req_ready    out  1            unit can accept; high only in IDLE
//  req_write    in   1            1=store, 0=load
//  req_size     in   2            00 byte, 01 half, 10 word; 11 reserved (flagged as error)
//  req_signed   in   1            load sign-extend (1) / zero-extend (0)
//  req_addr     in   ADDR_WIDTH   byte address
//  req_wdata    in   32           store data, right-justified
//  rsp_valid    out  1            one-cycle completion pulse (loads and stores)
//  rsp_rdata    out  32           extended load data; 0 for stores and errors
//  rsp_err      out  1            valid with rsp_valid: misaligned/reserved size/timeout
//  address      out  ADDR_WIDTH   Avalon address, aligned to BE_WIDTH bytes
//  read         out  1            Avalon read
//  write        out  1            Avalon write
//  waitrequest  in   1            Avalon stall
//  writedata    out  DATA_WIDTH   Avalon write data
//  byteenable   out  BE_WIDTH     Avalon byte lanes
//  readdata     in   DATA_WIDTH   Avalon read data; valid when read=1 and waitrequest=0
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE. All outputs 0 except req_ready=1.
//   Reset mid-transaction drops read/write immediately; the transaction is lost and gets no response.
//  FSM IDLE -> BUS -> RESP -> IDLE; IDLE -> ERR -> IDLE.
//  IDLE: accept on req_valid & req_ready (cycle N). All outputs are registered.
//   lane = req_addr mod BE_WIDTH.
//   Misaligned when: half with lane[0]=1, word with lane[1:0]!=0, or size 11.
//   If misaligned -> ERR: no bus access; rsp_valid=1, rsp_err=1, rsp_rdata=0 at N+1.
//  BUS (from N+1):
//   address = req_addr with low log2(BE_WIDTH) bits cleared.
//   byteenable: 1<<lane (byte), 2'b11<<lane (half), 4'hF<<lane (word).
//   writedata = size-masked req_wdata shifted left by 8*lane; all other bits 0.
//   read or write = 1. address, byteenable, writedata, read and write are held stable while waitrequest=1.
//   On the first cycle with waitrequest=0: capture readdata, clear read/write next edge, go RESP.
//  RESP: rsp_valid=1 for exactly one cycle, rsp_err=0.
//   rsp_rdata = readdata byte/half/word at lane, sign- or zero-extended per req_signed; 0 for stores.
//  Minimum latency: accept at N, bus strobe N+1, rsp_valid N+2. Each extra waitrequest cycle adds 1.
//  req_ready=0 in BUS/RESP/ERR; req_valid is ignored there and the request is not queued.
//  Zero-wait back-to-back: next accept at N+3.
//  Address wrap: no carry or overflow handling; the aligned address is passed through as-is.
// CONFIGURATION
//  MEM_IF_TIMEOUT_EN defined:
//   An 8..16-bit counter clears on BUS entry and increments each BUS cycle with waitrequest=1.
//   On reaching TIMEOUT_CYCLES: clear read/write, go RESP with rsp_err=1, rsp_rdata=0.
//   waitrequest=0 in that same cycle takes priority (normal completion).
//  Undefined: no counter; BUS waits indefinitely; rsp_err is set only by misalignment/size 11.
// TESTING
//  1 LW 0x1000, waitrequest=0, readdata=0xDEADBEEF -> address=0x1000, be=4'hF, read high 1 cycle (N+1), rsp 0xDEADBEEF at N+2.
//  2 LB 0x1003 signed, readdata=0x80123456 -> be=4'b1000, rsp 0xFFFFFF80; unsigned repeat -> 0x00000080.
//  3 SH 0x2002 wdata=0x1234ABCD, waitrequest high 3 cycles -> write high 4 cycles; address=0x2000, be=4'b1100, writedata=0xABCD0000, all stable; rsp_valid after drop.
//  4 LH 0x1001 -> read never asserts; rsp_valid=1, rsp_err=1 at N+1; req_ready=1 at N+2.
//  5 reset=0 during BUS with waitrequest=1 -> read=0 asynchronously, no rsp_valid; after release req_ready=1, next LW completes normally.
//  6 MEM_IF_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 -> read drops after 4 BUS cycles, rsp_err=1; undefined build -> read stays high.

Source files
------------

// File: rtl/mips_bus_mem_unit_if.sv
// ----------------------------------------------------------------------------
// Interfaces for mips_bus_mem_unit.
//
// mips_bus_mem_unit_req_if : core-side load/store request and response.
//     master = core, slave = load/store unit.
//     req_valid/req_ready handshake, req_write, req_size, req_signed,
//     req_addr, req_wdata; rsp_valid, rsp_rdata, rsp_err.
//
// mips_bus_mem_unit_avm_if : Avalon-MM bus port.
//     master = load/store unit, slave = memory/interconnect.
//     address, read, write, writedata, byteenable, waitrequest, readdata.
// ----------------------------------------------------------------------------
interface mips_bus_mem_unit_req_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface mips_bus_mem_unit_avm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_mem_unit.sv
// ----------------------------------------------------------------------------
// mips_bus_mem_unit
//   Load/store unit between the multicycle MIPS core and an Avalon-MM bus.
//   Takes one byte/half/word request, drives an aligned address with
//   byteenable and lane-shifted writedata, holds it while waitrequest is
//   high, then returns lane-extracted sign/zero-extended load data.
//   Misaligned accesses and the reserved size code complete immediately
//   with rsp_err and no bus cycle.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   core   : mips_bus_mem_unit_req_if.slave  (request / response)
//   bus    : mips_bus_mem_unit_avm_if.master (Avalon-MM master)
//
// Parameters
//   ADDR_WIDTH     : byte-address width (core and bus)
//   DATA_WIDTH     : bus width, 32 or 64
//   TIMEOUT_CYCLES : stalled BUS cycles before abort (timeout build only)
//
// Configuration macro
//   MEM_IF_TIMEOUT_EN : when defined, a waitrequest counter aborts a stuck
//                       bus access with rsp_err. Undefined: waits forever.
// ----------------------------------------------------------------------------
module mips_bus_mem_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    mips_bus_mem_unit_req_if.slave         core,
    mips_bus_mem_unit_avm_if.master        bus
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_W   = $clog2(BE_WIDTH);
    localparam int TO_BITS  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W    = (TO_BITS < 8) ? 8 : ((TO_BITS > 16) ? 16 : TO_BITS);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $error("mips_bus_mem_unit: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mips_bus_mem_unit: TIMEOUT_CYCLES must fit a 16-bit counter");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP,
        S_ERR
    } state_t;

    state_t                r_state, w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr,   w_addr_nxt;
    logic [BE_WIDTH-1:0]   r_be,     w_be_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,  w_wdata_nxt;
    logic                  r_read,   w_read_nxt;
    logic                  r_write,  w_write_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic                  r_rsp_err,   w_rsp_err_nxt;
    logic [31:0]           r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]            r_size,   w_size_nxt;
    logic                  r_signed, w_signed_nxt;
    logic [LANE_W-1:0]     r_lane,   w_lane_nxt;

    // Request-side decode
    logic [LANE_W-1:0]     w_lane;
    logic                  w_misalign;
    logic [BE_WIDTH-1:0]   w_be;
    logic [31:0]           w_wdata_sz;
    logic [DATA_WIDTH-1:0] w_wdata_lane;
    logic [ADDR_WIDTH-1:0] w_addr_al;

    // Response-side extraction
    logic [DATA_WIDTH-1:0] w_rd_shift;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_ld_data;

    always_comb begin
        w_lane     = core.req_addr[LANE_W-1:0];
        w_addr_al  = {core.req_addr[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
        w_misalign = 1'b0;
        w_be       = '0;
        w_wdata_sz = '0;
        unique case (core.req_size)
            2'b00: begin
                w_be       = BE_WIDTH'(1) << w_lane;
                w_wdata_sz = {24'h0, core.req_wdata[7:0]};
            end
            2'b01: begin
                w_misalign = w_lane[0];
                w_be       = BE_WIDTH'(2'b11) << w_lane;
                w_wdata_sz = {16'h0, core.req_wdata[15:0]};
            end
            2'b10: begin
                w_misalign = (w_lane[1:0] != 2'b00);
                w_be       = BE_WIDTH'(4'hF) << w_lane;
                w_wdata_sz = core.req_wdata;
            end
            default: begin
                w_misalign = 1'b1;
            end
        endcase
        w_wdata_lane = DATA_WIDTH'(w_wdata_sz) << {w_lane, 3'b000};
    end

    always_comb begin
        w_rd_shift = bus.readdata >> {r_lane, 3'b000};
        w_rd_word  = w_rd_shift[31:0];
        unique case (r_size)
            2'b00:   w_ld_data = {{24{r_signed & w_rd_word[7]}},  w_rd_word[7:0]};
            2'b01:   w_ld_data = {{16{r_signed & w_rd_word[15]}}, w_rd_word[15:0]};
            default: w_ld_data = w_rd_word;
        endcase
    end

`ifdef MEM_IF_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_timeout;

    // Counter sits at zero outside BUS, so it is clear on every BUS entry.
    always_comb begin
        w_cnt_nxt = '0;
        if (r_state == S_BUS && bus.waitrequest) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        w_timeout = bus.waitrequest && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    logic w_timeout;
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic; every output is a register.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_be_nxt        = r_be;
        w_wdata_nxt     = r_wdata;
        w_read_nxt      = r_read;
        w_write_nxt     = r_write;
        w_size_nxt      = r_size;
        w_signed_nxt    = r_signed;
        w_lane_nxt      = r_lane;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;

        unique case (r_state)
            S_IDLE: begin
                if (core.req_valid) begin
                    w_size_nxt   = core.req_size;
                    w_signed_nxt = core.req_signed;
                    w_lane_nxt   = w_lane;
                    if (w_misalign) begin
                        w_state_nxt     = S_ERR;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_BUS;
                        w_addr_nxt  = w_addr_al;
                        w_be_nxt    = w_be;
                        w_wdata_nxt = w_wdata_lane;
                        w_read_nxt  = ~core.req_write;
                        w_write_nxt = core.req_write;
                    end
                end
            end
            S_BUS: begin
                // A completing cycle wins over a timeout in the same cycle.
                if (!bus.waitrequest || w_timeout) begin
                    w_state_nxt     = S_RESP;
                    w_addr_nxt      = '0;
                    w_be_nxt        = '0;
                    w_wdata_nxt     = '0;
                    w_read_nxt      = 1'b0;
                    w_write_nxt     = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    if (bus.waitrequest) begin
                        w_rsp_err_nxt = 1'b1;
                    end else if (!r_write) begin
                        w_rsp_rdata_nxt = w_ld_data;
                    end
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_lane      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_addr      <= w_addr_nxt;
            r_be        <= w_be_nxt;
            r_wdata     <= w_wdata_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_size      <= w_size_nxt;
            r_signed    <= w_signed_nxt;
            r_lane      <= w_lane_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign core.req_ready  = (r_state == S_IDLE);
    assign core.rsp_valid  = r_rsp_valid;
    assign core.rsp_err    = r_rsp_err;
    assign core.rsp_rdata  = r_rsp_rdata;
    assign bus.address     = r_addr;
    assign bus.byteenable  = r_be;
    assign bus.writedata   = r_wdata;
    assign bus.read        = r_read;
    assign bus.write       = r_write;

endmodule

// File: tb/tb_mips_bus_mem_unit.sv
module tb_mips_bus_mem_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mips_bus_mem_unit_req_if #(.ADDR_WIDTH(AW)) core_if ();
    mips_bus_mem_unit_avm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    mips_bus_mem_unit #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .core (core_if),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Bus-slave storage (word array) and request-level byte model.
    logic [31:0] slave_mem [64];
    logic [7:0]  refb [256];

    // Observations from the last transaction.
    int          t_lat, t_strobes, t_first_c, t_acc_cyc;
    bit          t_stable, t_timeout, t_accept_ok, t_ready_after, t_busy_after;
    bit          t_rd, t_wr, t_err;
    logic [31:0] t_addr, t_rdata, t_wd;
    logic [3:0]  t_be;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        slave_mem[idx] = v;
        for (int k = 0; k < 4; k++) refb[idx*4 + k] = v[8*k +: 8];
    endtask

    // Drives one request, plays an Avalon slave with 'waits' stall cycles,
    // and records what was seen. Checking is left to the caller.
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input bit hold_busy);
        logic [5:0] idx;
        t_accept_ok = core_if.req_ready;
        core_if.req_valid  = 1'b1;
        core_if.req_write  = wr;
        core_if.req_size   = sz;
        core_if.req_signed = sg;
        core_if.req_addr   = addr;
        core_if.req_wdata  = wd;
        t_acc_cyc = cyc;
        tick;
        core_if.req_valid = hold_busy;
        core_if.req_addr  = $urandom;
        core_if.req_wdata = $urandom;
        core_if.req_write = 1'($urandom);
        core_if.req_size  = 2'($urandom);
        t_strobes = 0; t_stable = 1; t_lat = 0; t_timeout = 1; t_first_c = -1;
        t_rd = 0; t_wr = 0; t_err = 0; t_rdata = '0;
        for (int c = 0; c < 60; c++) begin
            if (bus_if.read || bus_if.write) begin
                if (t_strobes == 0) begin
                    t_first_c = c;
                    t_addr = bus_if.address; t_be = bus_if.byteenable; t_wd = bus_if.writedata;
                    t_rd = bus_if.read; t_wr = bus_if.write;
                end else if (bus_if.address !== t_addr || bus_if.byteenable !== t_be ||
                             bus_if.writedata !== t_wd || bus_if.read !== t_rd ||
                             bus_if.write !== t_wr) begin
                    t_stable = 0;
                end
                t_strobes++;
            end
            if (core_if.rsp_valid) begin
                t_lat = c + 1; t_rdata = core_if.rsp_rdata; t_err = core_if.rsp_err;
                t_timeout = 0;
                break;
            end
            bus_if.waitrequest = (c < waits);
            idx = bus_if.address[7:2];
            bus_if.readdata = slave_mem[idx];
            if (bus_if.write && !bus_if.waitrequest)
                for (int k = 0; k < 4; k++)
                    if (bus_if.byteenable[k]) slave_mem[idx][8*k +: 8] = bus_if.writedata[8*k +: 8];
            tick;
        end
        core_if.req_valid  = 1'b0;
        bus_if.waitrequest = 1'b0;
        tick;
        t_ready_after = core_if.req_ready;
        t_busy_after  = bus_if.read | bus_if.write | core_if.rsp_valid;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++;
        if ({core_if.req_ready, core_if.rsp_valid, core_if.rsp_err, bus_if.read, bus_if.write} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=10000",
                     {core_if.req_ready, core_if.rsp_valid, core_if.rsp_err, bus_if.read, bus_if.write});
        end
        checks++;
        if ({bus_if.address, bus_if.byteenable, bus_if.writedata, core_if.rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus_if.address, bus_if.byteenable,
                     bus_if.writedata, core_if.rsp_rdata);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_lw;
        set_word(0, 32'hDEADBEEF);
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, 0);
        checks++; if (t_addr !== 32'h1000) begin errors++; $display("FAIL lw_addr got=%h exp=00001000", t_addr); end
        checks++; if (t_be !== 4'hF) begin errors++; $display("FAIL lw_be got=%h exp=f", t_be); end
        checks++; if ({t_rd, t_wr, t_first_c, t_strobes} !== {1'b1, 1'b0, 32'd0, 32'd1}) begin
            errors++; $display("FAIL lw_strobe got rd=%0d wr=%0d first=%0d n=%0d exp 1 0 0 1", t_rd, t_wr, t_first_c, t_strobes); end
        checks++; if (t_lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", t_lat); end
        checks++; if ({t_err, t_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL lw_rdata got=%h err=%0d exp=deadbeef err=0", t_rdata, t_err); end
        checks++; if ({t_ready_after, t_busy_after} !== 2'b10) begin
            errors++; $display("FAIL lw_after got ready=%0d busy=%0d exp 1 0", t_ready_after, t_busy_after); end
    endtask

    task automatic test_lb;
        set_word(0, 32'h80123456);
        run_txn(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 0, 0);
        checks++; if (t_be !== 4'b1000) begin errors++; $display("FAIL lb_be got=%b exp=1000", t_be); end
        checks++; if (t_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got=%h exp=ffffff80", t_rdata); end
        run_txn(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 0, 0);
        checks++; if (t_rdata !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned got=%h exp=00000080", t_rdata); end
    endtask

    task automatic test_sh_wait;
        set_word(0, 32'h55667788);
        run_txn(1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234ABCD, 3, 0);
        checks++; if ({t_wr, t_rd, t_strobes} !== {1'b1, 1'b0, 32'd4}) begin
            errors++; $display("FAIL sh_strobes got wr=%0d rd=%0d n=%0d exp 1 0 4", t_wr, t_rd, t_strobes); end
        checks++; if ({t_addr, t_be, t_wd} !== {32'h2000, 4'b1100, 32'hABCD0000}) begin
            errors++; $display("FAIL sh_bus got=%h/%b/%h exp=00002000/1100/abcd0000", t_addr, t_be, t_wd); end
        checks++; if (t_stable !== 1'b1) begin errors++; $display("FAIL sh_stable got=0 exp=1"); end
        checks++; if ({t_lat, t_err, t_rdata} !== {32'd5, 1'b0, 32'h0}) begin
            errors++; $display("FAIL sh_rsp got lat=%0d err=%0d rd=%h exp 5 0 0", t_lat, t_err, t_rdata); end
        checks++; if (slave_mem[0] !== 32'hABCD7788) begin
            errors++; $display("FAIL sh_mem got=%h exp=abcd7788", slave_mem[0]); end
    endtask

    task automatic test_misaligned;
        logic [1:0]  szs [3]   = '{2'b01, 2'b10, 2'b11};
        logic [31:0] adrs [3]  = '{32'h1001, 32'h1002, 32'h1000};
        for (int i = 0; i < 3; i++) begin
            run_txn(1'($urandom), szs[i], 1'b1, adrs[i], $urandom, 0, 0);
            checks++; if ({t_strobes, t_lat, t_err, t_rdata, t_ready_after} !== {32'd0, 32'd1, 1'b1, 32'h0, 1'b1}) begin
                errors++; $display("FAIL misalign_%0d got n=%0d lat=%0d err=%0d rd=%h rdy=%0d exp 0 1 1 0 1",
                                   i, t_strobes, t_lat, t_err, t_rdata, t_ready_after); end
        end
    endtask

    task automatic test_reset_mid;
        set_word(0, 32'hCAFEF00D);
        core_if.req_valid = 1'b1; core_if.req_write = 1'b0; core_if.req_size = 2'b10;
        core_if.req_signed = 1'b0; core_if.req_addr = 32'h1000;
        bus_if.waitrequest = 1'b1;
        tick;
        core_if.req_valid = 1'b0;
        tick;
        checks++; if (bus_if.read !== 1'b1) begin errors++; $display("FAIL rstmid_pre got read=%0d exp=1", bus_if.read); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus_if.read, core_if.rsp_valid, core_if.req_ready} !== 3'b001) begin
            errors++; $display("FAIL rstmid_async got=%b exp=001", {bus_if.read, core_if.rsp_valid, core_if.req_ready}); end
        bus_if.waitrequest = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        checks++; if ({bus_if.read, core_if.rsp_valid, core_if.req_ready} !== 3'b001) begin
            errors++; $display("FAIL rstmid_release got=%b exp=001", {bus_if.read, core_if.rsp_valid, core_if.req_ready}); end
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 0);
        checks++; if ({t_lat, t_err, t_rdata} !== {32'd3, 1'b0, 32'hCAFEF00D}) begin
            errors++; $display("FAIL rstmid_next got lat=%0d err=%0d rd=%h exp 3 0 cafef00d", t_lat, t_err, t_rdata); end
    endtask

    task automatic test_timeout;
        set_word(0, 32'h11223344);
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 20, 0);
`ifdef MEM_IF_TIMEOUT_EN
        checks++; if ({t_strobes, t_lat, t_err, t_rdata} !== {32'd4, 32'd5, 1'b1, 32'h0}) begin
            errors++; $display("FAIL timeout_abort got n=%0d lat=%0d err=%0d rd=%h exp 4 5 1 0",
                               t_strobes, t_lat, t_err, t_rdata); end
`else
        checks++; if ({t_strobes, t_lat, t_err, t_rdata} !== {32'd21, 32'd22, 1'b0, 32'h11223344}) begin
            errors++; $display("FAIL timeout_none got n=%0d lat=%0d err=%0d rd=%h exp 21 22 0 11223344",
                               t_strobes, t_lat, t_err, t_rdata); end
`endif
        // waitrequest falls in the cycle the counter would expire: normal completion
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, TO - 1, 0);
        checks++; if ({t_strobes, t_lat, t_err, t_rdata} !== {32'(TO), 32'(TO + 1), 1'b0, 32'h11223344}) begin
            errors++; $display("FAIL timeout_edge got n=%0d lat=%0d err=%0d rd=%h exp %0d %0d 0 11223344",
                               t_strobes, t_lat, t_err, t_rdata, TO, TO + 1); end
    endtask

    task automatic test_back_to_back;
        int prev;
        set_word(5, 32'hA5A5_0F0F);
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            prev = t_acc_cyc;
            run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0016, 32'h0, 0, 0);
            checks++; if ({t_accept_ok, 32'(t_acc_cyc - prev), t_rdata} !== {1'b1, 32'd3, 32'hFFFFA5A5}) begin
                errors++; $display("FAIL b2b_%0d got ok=%0d gap=%0d rd=%h exp 1 3 ffffa5a5",
                                   i, t_accept_ok, t_acc_cyc - prev, t_rdata); end
        end
    endtask

    task automatic test_busy_ignored;
        set_word(2, 32'h0BAD_F00D);
        run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1357_9BDF, 2, 1);
        checks++; if ({t_stable, t_strobes, t_lat, t_busy_after, t_ready_after} !== {1'b1, 32'd3, 32'd4, 1'b0, 1'b1}) begin
            errors++; $display("FAIL busy_ignore got st=%0d n=%0d lat=%0d busy=%0d rdy=%0d exp 1 3 4 0 1",
                               t_stable, t_strobes, t_lat, t_busy_after, t_ready_after); end
        refb[8] = 8'hDF; refb[9] = 8'h9B; refb[10] = 8'h57; refb[11] = 8'h13;
    endtask

    task automatic test_random;
        logic        wr, sg;
        logic [1:0]  sz;
        logic [31:0] addr, wd, exp_rd, exp_wd;
        logic [3:0]  exp_be;
        int          n, lane, waits, r, fails_before;
        bit          mis;
        longint      v;
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        fails_before = errors;
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 7);
            sz = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            wr = 1'($urandom); sg = 1'($urandom); wd = $urandom; addr = $urandom;
            waits = $urandom_range(0, 3);
            n = 1 << sz;
            lane = addr % 4;
            mis = (sz == 2'b11) || ((addr % n) != 0);
            exp_be = 4'(((1 << n) - 1) << lane);
            exp_wd = 32'((longint'(wd) & ((64'd1 << (8 * n)) - 1)) << (8 * lane));
            exp_rd = '0;
            if (!mis && !wr) begin
                v = 0;
                for (int k = 0; k < n; k++) v += longint'(refb[(addr + k) % 256]) << (8 * k);
                if (sg && v >= (64'd1 << (8 * n - 1))) v -= (64'd1 << (8 * n));
                exp_rd = 32'(v);
            end
            if (!mis && wr)
                for (int k = 0; k < n; k++) refb[(addr + k) % 256] = 8'(wd >> (8 * k));
            run_txn(wr, sz, sg, addr, wd, waits, 0);
            checks++;
            if (mis) begin
                if ({t_strobes, t_lat, t_err, t_rdata} !== {32'd0, 32'd1, 1'b1, 32'h0}) begin
                    errors++; $display("FAIL rnd_%0d_err a=%h sz=%0d got n=%0d lat=%0d err=%0d rd=%h",
                                       t, addr, sz, t_strobes, t_lat, t_err, t_rdata); end
            end else if ({t_addr, t_be, t_rd, t_wr, t_first_c, t_strobes, t_stable, t_lat, t_err, t_rdata} !==
                         {addr & 32'hFFFF_FFFC, exp_be, ~wr, wr, 32'd0, 32'(waits + 1), 1'b1, 32'(waits + 2), 1'b0, exp_rd}
                         || (wr && t_wd !== exp_wd)) begin
                errors++; $display("FAIL rnd_%0d a=%h sz=%0d wr=%0d sg=%0d got adr=%h be=%b wd=%h n=%0d lat=%0d st=%0d err=%0d rd=%h exp adr=%h be=%b wd=%h lat=%0d rd=%h",
                                   t, addr, sz, wr, sg, t_addr, t_be, t_wd, t_strobes, t_lat, t_stable, t_err, t_rdata,
                                   addr & 32'hFFFF_FFFC, exp_be, exp_wd, waits + 2, exp_rd); end
            if (errors - fails_before > 10) break;
        end
    endtask

    initial begin
        core_if.req_valid  = 1'b0;
        core_if.req_write  = 1'b0;
        core_if.req_size   = 2'b00;
        core_if.req_signed = 1'b0;
        core_if.req_addr   = '0;
        core_if.req_wdata  = '0;
        bus_if.waitrequest = 1'b0;
        bus_if.readdata    = '0;
        for (int i = 0; i < 64; i++) set_word(i, 32'h0);
        test_reset;
        test_lw;
        test_lb;
        test_sh_wait;
        test_misaligned;
        test_reset_mid;
        test_timeout;
        test_back_to_back;
        test_busy_ignored;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
